// File: rtl/div_pkg.sv
// Shared types and constants for the iterative signed 32-bit divider.
package div_pkg;

   localparam int          DIV_WIDTH = 32;
   localparam int          DIV_ITER  = 32;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;
   localparam logic [31:0] NEG_ONE   = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_32bit_if.sv
// Divider request/response bundle between the multdiv controller and
// div_32bit. DIV_REMAINDER_EN adds the signed remainder output.
interface div_32bit_if;
   import div_pkg::*;

   logic [DIV_WIDTH-1:0] data_operandA;
   logic [DIV_WIDTH-1:0] data_operandB;
   logic                 ctrl_DIV;
   logic [DIV_WIDTH-1:0] data_result;
   logic                 data_exception;
   logic                 data_resultRDY;
`ifdef DIV_REMAINDER_EN
   logic [DIV_WIDTH-1:0] data_remainder;

   modport master (output data_operandA, data_operandB, ctrl_DIV,
                   input  data_result, data_exception, data_resultRDY, data_remainder);
   modport slave  (input  data_operandA, data_operandB, ctrl_DIV,
                   output data_result, data_exception, data_resultRDY, data_remainder);
`else
   modport master (output data_operandA, data_operandB, ctrl_DIV,
                   input  data_result, data_exception, data_resultRDY);
   modport slave  (input  data_operandA, data_operandB, ctrl_DIV,
                   output data_result, data_exception, data_resultRDY);
`endif

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes:
// shift {R,Q} left, trial-subtract M, keep the difference if it is non-negative.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   i_r,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_m,
   output logic [WIDTH:0]   o_r,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH+1:0] w_sh;
   logic [WIDTH+1:0] w_t;

   // R stays below M, so after the shift it fits in WIDTH+1 bits; the
   // extra top bit of the trial difference is the borrow/sign.
   always_comb begin
      w_sh = {i_r, i_q[WIDTH-1]};
      w_t  = w_sh - {2'b00, i_m};
      if (!w_t[WIDTH+1]) begin
         o_r = w_t[WIDTH:0];
         o_q = {i_q[WIDTH-2:0], 1'b1};
      end else begin
         o_r = w_sh[WIDTH:0];
         o_q = {i_q[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_32bit.sv
// Iterative signed 32-bit divider, one quotient bit per clock.
// Start-pulse / ready-pulse handshake; quotient truncates toward zero,
// divide-by-zero and INT_MIN/-1 raise data_exception.
// Optional: define DIV_REMAINDER_EN to add the signed remainder output.
module div_32bit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic       clock,
   input  logic       reset,
   div_32bit_if.slave bus
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DIV_ITER);

   div_state_t       r_state, w_next_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_q, r_m;
   logic [WIDTH:0]   r_r;
   logic             r_sign_q, r_divz, r_ovf;
   logic [WIDTH-1:0] r_result;
   logic             r_exc;

   logic [WIDTH-1:0] w_abs_a, w_abs_b;
   logic [WIDTH:0]   w_step_r;
   logic [WIDTH-1:0] w_step_q;
   logic [WIDTH-1:0] w_q_signed;
   logic             w_last;

`ifdef DIV_REMAINDER_EN
   logic             r_sign_r;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] w_r_signed;
`endif

   // Magnitudes of the operands; |INT_MIN| is kept as an unsigned value.
   always_comb begin
      w_abs_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
      w_abs_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
   end

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_r (r_r),
      .i_q (r_q),
      .i_m (r_m),
      .o_r (w_step_r),
      .o_q (w_step_q)
   );

   // Sign fix-up of the magnitude results; -0 is naturally 0.
   always_comb begin
      w_q_signed = r_sign_q ? -r_q : r_q;
      w_last     = (r_state == RUN) && (r_cnt == LP_LAST);
   end

`ifdef DIV_REMAINDER_EN
   // Remainder takes the dividend's sign so that A = q*B + r.
   always_comb begin
      w_r_signed = r_sign_r ? -r_r[WIDTH-1:0] : r_r[WIDTH-1:0];
   end
`endif

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // Next state: a start pulse wins from any state; RUN spends 32 steps
   // plus one result-write edge so latency is fixed for every operand.
   always_comb begin
      w_next_state = r_state;
      if (bus.ctrl_DIV) begin
         w_next_state = RUN;
      end else begin
         case (r_state)
            IDLE:    w_next_state = IDLE;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
         endcase
      end
   end

   // Datapath: load on start, iterate in RUN, write outputs entering DONE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_r      <= '0;
         r_sign_q <= 1'b0;
         r_divz   <= 1'b0;
         r_ovf    <= 1'b0;
         r_result <= '0;
         r_exc    <= 1'b0;
`ifdef DIV_REMAINDER_EN
         r_sign_r <= 1'b0;
         r_rem    <= '0;
`endif
      end else if (bus.ctrl_DIV) begin
         r_cnt    <= '0;
         r_q      <= w_abs_a;
         r_m      <= w_abs_b;
         r_r      <= '0;
         r_sign_q <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
         r_divz   <= (bus.data_operandB == '0);
         r_ovf    <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == NEG_ONE);
`ifdef DIV_REMAINDER_EN
         r_sign_r <= bus.data_operandA[WIDTH-1];
`endif
      end else if (r_state == RUN) begin
         if (w_last) begin
            if (r_divz) begin
               r_result <= '0;
               r_exc    <= 1'b1;
            end else if (r_ovf) begin
               r_result <= INT_MIN;
               r_exc    <= 1'b1;
            end else begin
               r_result <= w_q_signed;
               r_exc    <= 1'b0;
            end
`ifdef DIV_REMAINDER_EN
            r_rem <= (r_divz || r_ovf) ? '0 : w_r_signed;
`endif
         end else begin
            r_r   <= w_step_r;
            r_q   <= w_step_q;
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.data_result    = r_result;
   assign bus.data_exception = r_exc;
   assign bus.data_resultRDY = (r_state == DONE);
`ifdef DIV_REMAINDER_EN
   assign bus.data_remainder = r_rem;
`endif

endmodule

// File: tb/tb_div_32bit.sv
// Self-checking bench for div_32bit: vector table plus random operands
// through a scoreboard, abort/restart and mid-run reset sequences, and a
// few direct checks of the div_step iteration.
module tb_div_32bit;
   import div_pkg::*;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        exc;
   } vec_t;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        exc;
   } exp_t;

   logic clk, rst;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   div_32bit_if bus ();

   div_32bit #(.WIDTH(32), .CNT_W(6)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   // Standalone instance of the iteration for direct checks.
   logic [32:0] st_ri, st_ro;
   logic [31:0] st_qi, st_mi, st_qo;
   div_step #(.WIDTH(32)) u_step_chk (
      .i_r (st_ri), .i_q (st_qi), .i_m (st_mi), .o_r (st_ro), .o_q (st_qo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: compare every ready pulse against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && bus.data_resultRDY) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rdy: got rdy=1 expected no pending result");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_result", {1'b0, bus.data_result}, {1'b0, e.q});
            check("sb_exception", {32'd0, bus.data_exception}, {32'd0, e.exc});
`ifdef DIV_REMAINDER_EN
            check("sb_remainder", {1'b0, bus.data_remainder}, {1'b0, e.r});
`endif
         end
      end
   end

   // Drive one start pulse; returns #1 after edge 0 with ctrl_DIV low.
   task automatic start(input logic [31:0] a, input logic [31:0] b);
      bus.data_operandA = a;
      bus.data_operandB = b;
      bus.ctrl_DIV      = 1'b1;
      @(posedge clk); #1;
      bus.ctrl_DIV      = 1'b0;
   endtask

   // Edges after the start edge until ready is seen; -1 on timeout.
   task automatic wait_rdy(output int lat);
      lat = -1;
      for (int n = 1; n <= 80; n++) begin
         @(posedge clk); #1;
         if (bus.data_resultRDY) begin
            lat = n;
            return;
         end
      end
   endtask

   task automatic run_vec(input string name, input vec_t v);
      exp_t e;
      int   lat;
      e.q = v.q; e.r = v.r; e.exc = v.exc;
      sb.push_back(e);
      start(v.a, v.b);
      wait_rdy(lat);
      check({name, "_latency"}, 33'(lat), 33'd33);
      @(posedge clk); #1;
      check({name, "_rdy_pulse"}, {32'd0, bus.data_resultRDY}, 33'd0);
      check({name, "_hold"}, {1'b0, bus.data_result}, {1'b0, v.q});
   endtask

   vec_t vecs[16];

   initial begin
      int    lat, seen;
      vec_t  v;
      exp_t  e;

      vecs[0]  = '{32'd100,        32'd7,          32'd14,          32'd2,           1'b0};
      vecs[1]  = '{-32'sd100,      32'd7,          -32'sd14,        -32'sd2,         1'b0};
      vecs[2]  = '{32'd100,        -32'sd7,        -32'sd14,        32'd2,           1'b0};
      vecs[3]  = '{-32'sd100,      -32'sd7,        32'd14,          -32'sd2,         1'b0};
      vecs[4]  = '{32'd12345,      32'd0,          32'd0,           32'd0,           1'b1};
      vecs[5]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   32'd0,           1'b1};
      vecs[6]  = '{32'h8000_0000,  32'd1,          32'h8000_0000,   32'd0,           1'b0};
      vecs[7]  = '{32'd0,          -32'sd5,        32'd0,           32'd0,           1'b0};
      vecs[8]  = '{32'd3,          32'd5,          32'd0,           32'd3,           1'b0};
      vecs[9]  = '{-32'sd3,        32'd5,          32'd0,           -32'sd3,         1'b0};
      vecs[10] = '{32'h7FFF_FFFF,  32'd2,          32'h3FFF_FFFF,   32'd1,           1'b0};
      vecs[11] = '{32'h8000_0000,  32'd2,          32'hC000_0000,   32'd0,           1'b0};
      vecs[12] = '{32'h8000_0000,  32'd7,          -32'sd306783378, -32'sd2,         1'b0};
      vecs[13] = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd0,           32'hFFFF_FFFF,   1'b0};
      vecs[14] = '{32'h8000_0000,  32'h8000_0000,  32'd1,           32'd0,           1'b0};
      vecs[15] = '{32'd0,          32'd0,          32'd0,           32'd0,           1'b1};

      bus.data_operandA = '0;
      bus.data_operandB = '0;
      bus.ctrl_DIV      = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", {1'b0, bus.data_result}, 33'd0);
      check("reset_exception", {32'd0, bus.data_exception}, 33'd0);
      check("reset_rdy", {32'd0, bus.data_resultRDY}, 33'd0);
`ifdef DIV_REMAINDER_EN
      check("reset_remainder", {1'b0, bus.data_remainder}, 33'd0);
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // Single iteration, exercised directly.
      st_ri = 33'd5; st_qi = 32'd0; st_mi = 32'd7; #1;
      check("step_sub_r", st_ro, 33'd3);
      check("step_sub_q", {1'b0, st_qo}, 33'd1);
      st_ri = 33'd2; st_qi = 32'h8000_0000; st_mi = 32'd7; #1;
      check("step_keep_r", st_ro, 33'd5);
      check("step_keep_q", {1'b0, st_qo}, 33'd0);
      st_ri = 33'h0_7FFF_FFFF; st_qi = 32'hFFFF_FFFF; st_mi = 32'h8000_0000; #1;
      check("step_wide_r", st_ro, 33'h0_7FFF_FFFF);
      check("step_wide_q", {1'b0, st_qo}, 33'h0_FFFF_FFFF);

      for (int i = 0; i < 16; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Random operands against the language's truncating division.
      for (int i = 0; i < 8; i++) begin
         int sa, sb_;
         v.a = $urandom;
         v.b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if (i == 0) v.a = -32'sd77;
         sa = v.a; sb_ = v.b;
         if (v.b == 32'd0) begin
            v.q = '0; v.r = '0; v.exc = 1'b1;
         end else if (v.a == INT_MIN && v.b == NEG_ONE) begin
            v.q = INT_MIN; v.r = '0; v.exc = 1'b1;
         end else begin
            v.q = sa / sb_; v.r = sa % sb_; v.exc = 1'b0;
         end
         run_vec($sformatf("rand%0d", i), v);
      end

      // Abort: a second start mid-run discards the first operation.
      e.q = 32'd100; e.r = 32'd0; e.exc = 1'b0;
      sb.push_back(e);
      start(32'd1000, 32'd10);
      repeat (14) @(posedge clk);
      #1;
      sb.delete();
      e.q = 32'd9; e.r = 32'd0; e.exc = 1'b0;
      sb.push_back(e);
      start(32'd81, 32'd9);
      wait_rdy(lat);
      check("abort_latency", 33'(lat), 33'd33);
      @(posedge clk); #1;
      check("abort_rdy_pulse", {32'd0, bus.data_resultRDY}, 33'd0);

      // Reset in the middle of an operation.
      start(32'd5000, 32'd3);
      repeat (19) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midreset_result", {1'b0, bus.data_result}, 33'd0);
      check("midreset_exception", {32'd0, bus.data_exception}, 33'd0);
      check("midreset_rdy", {32'd0, bus.data_resultRDY}, 33'd0);
`ifdef DIV_REMAINDER_EN
      check("midreset_remainder", {1'b0, bus.data_remainder}, 33'd0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (bus.data_resultRDY) seen++;
      end
      check("midreset_no_rdy", 33'(seen), 33'd0);
      v = '{32'd5000, 32'd3, 32'd1666, 32'd2, 1'b0};
      run_vec("after_reset", v);

      @(posedge clk); #1;
      check("sb_empty", 33'(sb.size()), 33'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
